if_fetch_unit: RTL

Instruction-fetch stage that consumes the hazard unit's control outputs (PC_Write, PC_Mux_select, IF_ID_Stall, IF_ID_Flush, EPC_Selected). Owns the PC register, issues requests to instruction memory over a req/ready handshake, and drives the IF/ID pipeline register toward decode. Handles redirects that arrive while a fetch is outstanding by discarding the stale response.

---
 rtl/if_fetch_unit.sv | 93 +++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage with PC, imem req/ready handshake and IF/ID register (optional skid buffer: FETCH_SKID_EN)
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PC_Write,
  input  logic [1:0]  PC_Mux_select,
  input  logic        IF_ID_Stall,
  input  logic        IF_ID_Flush,
  input  logic        EPC_Selected,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_Instr,
  output logic        IF_ID_Valid
);
  typedef enum logic [1:0] {S_RESET, S_FETCH, S_WAIT_DROP} state_t;
  state_t state, state_nx;
  logic [31:0] pc, drop_addr, target, skid_pc, skid_instr;
  logic redirect, hit, accept, skid_v, skid_take, skid_drain;
  always_ff @(posedge clk)
    state <= reset ? S_RESET : state_nx;
  always_comb begin
    redirect = state != S_RESET && (EPC_Selected || (PC_Write && (PC_Mux_select == 2'b01 || PC_Mux_select == 2'b10)));
    target   = (EPC_Selected ? EXC_VECTOR : PC_Mux_select == 2'b10 ? jump_target : branch_target) & ~32'h3;
    hit      = state == S_FETCH && imem_req && imem_ready && !redirect;
    accept   = hit && !IF_ID_Flush && !IF_ID_Stall;
    state_nx = state == S_RESET ? S_FETCH :
               state == S_FETCH ? (redirect && imem_req && !imem_ready ? S_WAIT_DROP : S_FETCH) :
               (imem_ready ? S_FETCH : S_WAIT_DROP);
  end
  // Request and address come only from registers; the stale address is held while draining
  assign imem_req  = state != S_RESET && !skid_v;
  assign imem_addr = state == S_WAIT_DROP ? drop_addr : pc;
`ifdef FETCH_SKID_EN
  assign skid_take  = hit && !IF_ID_Flush && IF_ID_Stall;
  assign skid_drain = skid_v && !IF_ID_Flush && !IF_ID_Stall && !redirect;
  always_ff @(posedge clk) begin
    if (reset) begin
      skid_v     <= 1'b0;
      skid_pc    <= '0;
      skid_instr <= '0;
    end else if (IF_ID_Flush || redirect) begin
      skid_v <= 1'b0;
    end else if (skid_take) begin
      skid_v     <= 1'b1;
      skid_pc    <= pc + 32'd4;
      skid_instr <= imem_rdata;
    end else if (skid_drain) begin
      skid_v <= 1'b0;
    end
  end
`else
  assign skid_v     = 1'b0;
  assign skid_take  = 1'b0;
  assign skid_drain = 1'b0;
  assign skid_pc    = '0;
  assign skid_instr = '0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      drop_addr   <= '0;
      IF_ID_PC    <= '0;
      IF_ID_Instr <= '0;
      IF_ID_Valid <= 1'b0;
    end else begin
      if (state == S_FETCH && state_nx == S_WAIT_DROP) drop_addr <= pc;
      if (redirect) pc <= target;
      else if ((accept || skid_take) && PC_Write) pc <= pc + 32'd4;
      // Flush beats stall; an unstalled cycle without a delivered instruction inserts a bubble
      if (IF_ID_Flush) begin
        IF_ID_Valid <= 1'b0;
        IF_ID_Instr <= '0;
      end else if (!IF_ID_Stall) begin
        IF_ID_Valid <= accept || skid_drain;
        if (accept) begin
          IF_ID_PC    <= pc + 32'd4;
          IF_ID_Instr <= imem_rdata;
        end else if (skid_drain) begin
          IF_ID_PC    <= skid_pc;
          IF_ID_Instr <= skid_instr;
        end
      end
    end
  end
endmodule
